// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor input (in_*) and imem write bus (wr_*) of the instruction encoder; slave = encoder, master = feeder/imem side
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction descriptors into MIPS words and streams them to imem at consecutive addresses (clk, rst async; start_i/base_addr_i/count_i run control; bus = descriptor in + imem write out; busy_o/done_o/error_o status; cksum_o only with ENC_CHECKSUM_EN)
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  instr_encoder_if.slave    bus,
  output logic              busy_o,
  output logic              done_o,
`ifdef ENC_CHECKSUM_EN
  output logic              error_o,
  output logic [31:0]       cksum_o
`else
  output logic              error_o
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              wr_en_q, wr_en_d, error_q, error_d;
  logic [31:0]       wr_data_q, wr_data_d, word;
  logic [5:0]        op;
  logic              go, acc, load, xfer;
  assign go   = state_q == IDLE && start_i;
  assign xfer = wr_en_q && bus.wr_ready;
  assign bus.in_ready = state_q == RUN && rem_q != '0 && (!wr_en_q || bus.wr_ready);
  assign acc  = bus.in_valid && bus.in_ready;
  // illegal classes complete the handshake but never load the output register
  assign load = acc && bus.in_class < 3'd6;
  assign op = bus.in_class == 3'd1 ? 6'h23 : bus.in_class == 3'd2 ? 6'h2B : bus.in_class == 3'd3 ? 6'h04 : 6'h08;
  assign word = bus.in_class == 3'd0 ? {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct} :
                bus.in_class == 3'd4 ? {6'h02, bus.in_target} : {op, bus.in_rs, bus.in_rt, bus.in_imm};
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start_i) state_d = count_i == '0 ? DONE : RUN;
    // finish in the same edge the last word leaves so done follows the final transfer by one cycle
    else if (state_q == RUN && rem_q == '0 && (!wr_en_q || xfer)) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
    addr_d    = go ? base_addr_i : load ? addr_q + 1'b1 : addr_q;
    rem_d     = go ? count_i : load ? rem_q - 1'b1 : rem_q;
    wr_en_d   = load ? 1'b1 : xfer ? 1'b0 : wr_en_q;
    wr_data_d = load ? word : wr_data_q;
    wr_addr_d = load ? addr_q : wr_addr_q;
    error_d   = go ? 1'b0 : (acc && !load) ? 1'b1 : error_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      error_q   <= error_d;
    end
  end
`ifdef ENC_CHECKSUM_EN
  logic [31:0] cksum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cksum_q <= '0;
    else cksum_q <= go ? 32'd0 : xfer ? cksum_q ^ wr_data_q : cksum_q;
  end
  assign cksum_o = cksum_q;
`endif
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_addr = wr_addr_q;
  assign busy_o  = state_q != IDLE;
  assign done_o  = state_q == DONE;
  assign error_o = error_q;
endmodule
